// File: rtl/traffic_light_sequencer_pkg.sv
// Shared types for the traffic light sequencer.
// Mode codes, phase encoding, lamp patterns.
package traffic_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DAY   = 2'b00;
  localparam mode_t MODE_NIGHT = 2'b01;
  localparam mode_t MODE_PED   = 2'b10;
  localparam mode_t MODE_EMG   = 2'b11;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    WALK      = 3'd5,
    FLASH     = 3'd6,
    EMG_HOLD  = 3'd7
  } phase_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  typedef logic [2:0] light_t;

  localparam light_t LIGHT_R   = 3'b100;
  localparam light_t LIGHT_Y   = 3'b010;
  localparam light_t LIGHT_G   = 3'b001;
  localparam light_t LIGHT_OFF = 3'b000;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Mode/tick in, lamp and status out.
// master drives mode, slave is the sequencer.
interface traffic_light_sequencer_if;
  import traffic_pkg::*;

  mode_t  mode;
  logic   tick;
  light_t ns_light;
  light_t ew_light;
  logic   walk;
  phase_t phase;

  modport master (
    output mode, tick,
    input  ns_light, ew_light, walk, phase
  );

  modport slave (
    input  mode, tick,
    output ns_light, ew_light, walk, phase
  );

endinterface

// File: rtl/traffic_light_sequencer_phase_timer.sv
// Loadable down-counter with tick enable.
// expired is tick while the count sits at zero.
module phase_timer #(
  parameter int W       = 4,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expired
);

  logic [W-1:0] cnt;

  assign expired = tick && (cnt == '0);

  // Load wins; otherwise count down on ticks and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= W'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_sequencer.sv
// Two-way intersection phase sequencer.
// Day cycle, walk, night flash, emergency hold.
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 6,
  parameter int FLASH_TICKS  = 1
) (
  input logic                       clk,
  input logic                       rst_n,
  traffic_light_sequencer_if.slave  bus
);

  localparam int MAXD = imax(
    imax(imax(GREEN_TICKS, YELLOW_TICKS),
         imax(ALLRED_TICKS, WALK_TICKS)),
    FLASH_TICKS);
  localparam int CNT_W = $clog2(MAXD) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t FLASH_RELOAD = cnt_t'(FLASH_TICKS - 1);

  phase_t state;
  phase_t nxt;
  dir_t   last_dir;
  logic   ped_pending;
  logic   tog;
  logic   tog_n;
  logic   t_exp;
  logic   t_load;
  cnt_t   t_val;
  logic   f_exp;
  logic   f_load;
  logic   enter_flash;
  logic   flip;
  logic   emg;
  logic   night;
  light_t ns_n;
  light_t ew_n;
  logic   walk_n;

  function automatic cnt_t dur(phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   return cnt_t'(GREEN_TICKS - 1);
      NS_YELLOW, EW_YELLOW: return cnt_t'(YELLOW_TICKS - 1);
      WALK:                 return cnt_t'(WALK_TICKS - 1);
      default:              return cnt_t'(ALLRED_TICKS - 1);
    endcase
  endfunction

  assign emg   = (bus.mode == MODE_EMG);
  assign night = (bus.mode == MODE_NIGHT);

  assign t_load = (nxt != state);
  assign t_val  = dur(nxt);

  assign enter_flash = (nxt == FLASH) && (state != FLASH);
  assign flip        = (state == FLASH) && f_exp;
  assign f_load      = enter_flash || flip;
  assign tog_n       = enter_flash ? 1'b1 :
                       flip        ? ~tog : tog;

  phase_timer #(
    .W       (CNT_W),
    .RST_VAL (ALLRED_TICKS - 1)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .tick     (bus.tick),
    .expired  (t_exp)
  );

  phase_timer #(
    .W       (CNT_W),
    .RST_VAL (FLASH_TICKS - 1)
  ) u_flash (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (f_load),
    .load_val (FLASH_RELOAD),
    .tick     (bus.tick),
    .expired  (f_exp)
  );

  // Next phase: green/walk/flash exits on emergency, rest on expiry.
  always_comb begin
    nxt = state;
    case (state)
      ALL_RED: begin
        if (t_exp) begin
          if (emg)              nxt = EMG_HOLD;
          else if (ped_pending) nxt = WALK;
          else if (night)       nxt = FLASH;
          else if (last_dir == DIR_NS)
                                nxt = EW_GREEN;
          else                  nxt = NS_GREEN;
        end
      end
      NS_GREEN:  if (emg || t_exp) nxt = NS_YELLOW;
      EW_GREEN:  if (emg || t_exp) nxt = EW_YELLOW;
      NS_YELLOW: if (t_exp) nxt = ALL_RED;
      EW_YELLOW: if (t_exp) nxt = ALL_RED;
      WALK: begin
        if (emg)        nxt = EMG_HOLD;
        else if (t_exp) nxt = ALL_RED;
      end
      FLASH: begin
        if (emg)        nxt = EMG_HOLD;
        else if (!night) nxt = ALL_RED;
      end
      EMG_HOLD:  if (!emg) nxt = ALL_RED;
      default:   nxt = ALL_RED;
    endcase
  end

  // Lamp pattern for the phase being entered.
  always_comb begin
    ns_n   = LIGHT_R;
    ew_n   = LIGHT_R;
    walk_n = 1'b0;
    case (nxt)
      NS_GREEN:  ns_n = LIGHT_G;
      NS_YELLOW: ns_n = LIGHT_Y;
      EW_GREEN:  ew_n = LIGHT_G;
      EW_YELLOW: ew_n = LIGHT_Y;
      WALK:      walk_n = 1'b1;
      FLASH: begin
        ns_n = tog_n ? LIGHT_Y : LIGHT_OFF;
        ew_n = tog_n ? LIGHT_Y : LIGHT_OFF;
      end
      default: ;
    endcase
  end

  // Phase register, bookkeeping and registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ALL_RED;
      last_dir     <= DIR_EW;
      ped_pending  <= 1'b0;
      tog          <= 1'b1;
      bus.ns_light <= LIGHT_R;
      bus.ew_light <= LIGHT_R;
      bus.walk     <= 1'b0;
    end else begin
      state        <= nxt;
      tog          <= tog_n;
      bus.ns_light <= ns_n;
      bus.ew_light <= ew_n;
      bus.walk     <= walk_n;
      if (state == NS_YELLOW && t_exp)
        last_dir <= DIR_NS;
      else if (state == EW_YELLOW && t_exp)
        last_dir <= DIR_EW;
      if (nxt == WALK && state != WALK)
        ped_pending <= 1'b0;
      else if (bus.mode == MODE_PED && state != WALK)
        ped_pending <= 1'b1;
    end
  end

  assign bus.phase = state;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Vector table + scoreboard bench for the sequencer.
// GREEN=4 YELLOW=2 ALLRED=1 WALK=3 FLASH=2.
module tb_traffic_light_sequencer;
  import traffic_pkg::*;

  typedef struct {
    mode_t  mode;
    logic   tick;
    phase_t ph;
    logic   fl;
  } vec_t;

  typedef struct {
    light_t ns;
    light_t ew;
    logic   walk;
    phase_t ph;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   step;
  vec_t vecs[$];
  exp_t sb[$];

  traffic_light_sequencer_if tif ();

  traffic_light_sequencer #(
    .GREEN_TICKS  (4),
    .YELLOW_TICKS (2),
    .ALLRED_TICKS (1),
    .WALK_TICKS   (3),
    .FLASH_TICKS  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t expect_of(phase_t p, logic fl);
    exp_t e;
    e.ns   = LIGHT_R;
    e.ew   = LIGHT_R;
    e.walk = 1'b0;
    e.ph   = p;
    case (p)
      NS_GREEN:  e.ns = LIGHT_G;
      NS_YELLOW: e.ns = LIGHT_Y;
      EW_GREEN:  e.ew = LIGHT_G;
      EW_YELLOW: e.ew = LIGHT_Y;
      WALK:      e.walk = 1'b1;
      FLASH: begin
        e.ns = fl ? LIGHT_Y : LIGHT_OFF;
        e.ew = fl ? LIGHT_Y : LIGHT_OFF;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic void add(mode_t m, logic t,
                              phase_t p, logic f, int n);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.mode = m;
      v.tick = t;
      v.ph   = p;
      v.fl   = f;
      vecs.push_back(v);
    end
  endfunction

  task automatic check(string nm, exp_t e);
    n_checks++;
    if (tif.ns_light !== e.ns || tif.ew_light !== e.ew ||
        tif.walk !== e.walk || tif.phase !== e.ph) begin
      n_fail++;
      $display("FAIL %s: got ns=%b ew=%b walk=%b phase=%0d, want ns=%b ew=%b walk=%b phase=%0d",
               nm, tif.ns_light, tif.ew_light, tif.walk,
               tif.phase, e.ns, e.ew, e.walk, e.ph);
    end
  endtask

  task automatic run_vecs();
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      tif.mode = vecs[i].mode;
      tif.tick = vecs[i].tick;
      sb.push_back(expect_of(vecs[i].ph, vecs[i].fl));
      @(posedge clk);
      #1;
      step++;
      e = sb.pop_front();
      check($sformatf("step %0d", step), e);
    end
    vecs.delete();
  endtask

  initial begin
    phase_t p;
    n_checks = 0;
    n_fail   = 0;
    step     = 0;
    tif.mode = MODE_DAY;
    tif.tick = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset", expect_of(ALL_RED, 1'b0));

    // day cycle, period 14
    add(MODE_DAY, 1, NS_GREEN,  0, 4);
    add(MODE_DAY, 1, NS_YELLOW, 0, 2);
    add(MODE_DAY, 1, ALL_RED,   0, 1);
    add(MODE_DAY, 1, EW_GREEN,  0, 4);
    add(MODE_DAY, 1, EW_YELLOW, 0, 2);
    add(MODE_DAY, 1, ALL_RED,   0, 1);
    add(MODE_DAY, 1, NS_GREEN,  0, 1);
    // pedestrian pulse during NS green
    add(MODE_PED, 1, NS_GREEN,  0, 1);
    add(MODE_DAY, 1, NS_GREEN,  0, 2);
    add(MODE_DAY, 1, NS_YELLOW, 0, 2);
    add(MODE_DAY, 1, ALL_RED,   0, 1);
    add(MODE_DAY, 1, WALK,      0, 3);
    add(MODE_DAY, 1, ALL_RED,   0, 1);
    add(MODE_DAY, 1, EW_GREEN,  0, 2);
    // emergency at clock 2 of EW green
    add(MODE_EMG, 1, EW_YELLOW, 0, 2);
    add(MODE_EMG, 1, ALL_RED,   0, 1);
    add(MODE_EMG, 1, EMG_HOLD,  0, 3);
    add(MODE_DAY, 1, ALL_RED,   0, 1);
    add(MODE_DAY, 1, NS_GREEN,  0, 1);
    // night: finish cycle, then flash 2 on / 2 off
    add(MODE_NIGHT, 1, NS_GREEN,  0, 3);
    add(MODE_NIGHT, 1, NS_YELLOW, 0, 2);
    add(MODE_NIGHT, 1, ALL_RED,   0, 1);
    add(MODE_NIGHT, 1, FLASH,     1, 2);
    add(MODE_NIGHT, 1, FLASH,     0, 2);
    add(MODE_NIGHT, 1, FLASH,     1, 1);
    add(MODE_EMG,   1, EMG_HOLD,  0, 1);
    add(MODE_DAY,   1, ALL_RED,   0, 1);
    add(MODE_DAY,   1, EW_GREEN,  0, 1);
    // walk again, to be cut by reset
    add(MODE_PED, 1, EW_GREEN,  0, 1);
    add(MODE_DAY, 1, EW_GREEN,  0, 2);
    add(MODE_DAY, 1, EW_YELLOW, 0, 2);
    add(MODE_DAY, 1, ALL_RED,   0, 1);
    add(MODE_DAY, 1, WALK,      0, 2);

    rst_n = 1'b1;
    run_vecs();

    // asynchronous reset in the middle of a clock
    #2 rst_n = 1'b0;
    #1 check("async reset mid-walk", expect_of(ALL_RED, 1'b0));
    tif.mode = MODE_DAY;
    tif.tick = 1'b0;
    @(posedge clk);
    #1 check("held in reset", expect_of(ALL_RED, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // tick every third clock; emergency at a non-tick edge
    for (int i = 1; i <= 33; i++) begin
      if (i < 3)       p = ALL_RED;
      else if (i < 15) p = NS_GREEN;
      else if (i < 21) p = NS_YELLOW;
      else if (i < 24) p = ALL_RED;
      else if (i < 26) p = EW_GREEN;
      else if (i < 30) p = EW_YELLOW;
      else if (i < 33) p = ALL_RED;
      else             p = EMG_HOLD;
      add((i >= 26) ? MODE_EMG : MODE_DAY,
          (i % 3 == 0), p, 0, 1);
    end
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
